// File: rtl/store_writer.sv
// store_writer: commit-stage store responder, serialises SB/SH/SW into RAM byte writes.
// Optional STORE_WRITER_IO_STALL_EN: hold I/O-space bytes while the I/O buffer is full.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 3
`endif
`ifndef SB
`define SB 3'b000
`endif
`ifndef SH
`define SH 3'b001
`endif
`ifndef SW
`define SW 3'b010
`endif

module store_writer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int IO_SEL_HI = 17,
   parameter int IO_SEL_LO = 16,
   parameter logic [IO_SEL_HI-IO_SEL_LO:0] IO_SEL_VAL = 2'b11
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        rdy_in,
   input  logic                        rob_en_in,
   input  logic [ADDR_W-1:0]           rob_address_in,
   input  logic [DATA_W-1:0]           rob_wdata_in,
   input  logic [`INST_TYPE_WIDTH-1:0] rob_inst_type_in,
   output logic                        rob_rdy_out,
   output logic                        rob_finish_out,
   input  logic                        mem_grant_in,
   input  logic                        io_buffer_full_in,
   output logic                        mem_req_out,
   output logic [ADDR_W-1:0]           mem_a_out,
   output logic [7:0]                  mem_dout,
   output logic                        mem_wr_out
);

   localparam int NB = DATA_W / 8;
   localparam int IW = $clog2(NB + 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [DATA_W-1:0] data;
   logic [IW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [ADDR_W-1:0] last_a;
   logic [7:0]        last_d;

   logic [IW-1:0]     req_cnt;
   logic              req_ok;
   logic [ADDR_W-1:0] cur_a;
   logic [DATA_W-1:0] shifted;
   logic [7:0]        cur_d;
   logic              io_sel;
   logic              stall;
   logic              wr;

   always_comb begin
      req_cnt = '0;
      req_ok  = 1'b0;
      unique case (rob_inst_type_in)
         `SB: begin
            req_cnt = IW'(1);
            req_ok  = 1'b1;
         end
         `SH: begin
            req_cnt = IW'(2);
            req_ok  = 1'b1;
         end
         `SW: begin
            req_cnt = IW'(4);
            req_ok  = 1'b1;
         end
         default: begin
            req_cnt = '0;
            req_ok  = 1'b0;
         end
      endcase
   end

   // Byte address wraps naturally at 2^ADDR_W; no alignment check.
   assign cur_a   = base + ADDR_W'(idx);
   assign shifted = data >> {idx, 3'b000};
   assign cur_d   = shifted[7:0];
   assign io_sel  = (cur_a[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);

`ifdef STORE_WRITER_IO_STALL_EN
   assign stall = io_sel & io_buffer_full_in;
`else
   logic unused_io;
   assign unused_io = &{1'b0, io_sel, io_buffer_full_in};
   assign stall = 1'b0;
`endif

   assign wr = rdy_in & (state == WRITE) & mem_grant_in & ~stall;

   assign mem_wr_out     = wr;
   assign mem_a_out      = wr ? cur_a : last_a;
   assign mem_dout       = wr ? cur_d : last_d;
   assign mem_req_out    = (state == WRITE);
   assign rob_finish_out = rdy_in & (state == DONE);
   assign rob_rdy_out    = rst_n_in & (state == IDLE);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state  <= IDLE;
         base   <= '0;
         data   <= '0;
         cnt    <= '0;
         idx    <= '0;
         last_a <= '0;
         last_d <= '0;
      end else if (rdy_in) begin
         unique case (state)
            IDLE: begin
               if (rob_en_in && req_ok) begin
                  base  <= rob_address_in;
                  data  <= rob_wdata_in;
                  cnt   <= req_cnt;
                  idx   <= '0;
                  state <= WRITE;
               end
            end
            WRITE: begin
               if (wr) begin
                  last_a <= cur_a;
                  last_d <= cur_d;
                  idx    <= idx + IW'(1);
                  if (idx + IW'(1) == cnt)
                     state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
